// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the 8051 internal-RAM access sequencer: micro-op codes,
// FSM states, SFR boundary and op-class helpers.
package ram_ctrl_pkg;

  localparam logic [7:0] SFR_BASE_DEFAULT = 8'h80;

  typedef enum logic [3:0] {
    OP_RD_BYTE = 4'h0,
    OP_WR_BYTE = 4'h1,
    OP_INC     = 4'h2,
    OP_DEC     = 4'h3,
    OP_ANL     = 4'h4,
    OP_ORL     = 4'h5,
    OP_XRL     = 4'h6,
    OP_RD_BIT  = 4'h8,
    OP_SETB    = 4'h9,
    OP_CLR     = 4'hA,
    OP_CPL     = 4'hB,
    OP_MOV_BIT = 4'hC
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_MODIFY,
    ST_WRITE,
    ST_DONE
  } state_e;

  // Bit-addressed ops occupy the upper half of the op space.
  function automatic logic is_bit_op(input logic [3:0] op);
    return op[3];
  endfunction

  function automatic logic is_write_only(input logic [3:0] op);
    return (op == OP_WR_BYTE) || (op == OP_SETB) ||
           (op == OP_CLR)     || (op == OP_MOV_BIT);
  endfunction

  function automatic logic is_read_only(input logic [3:0] op);
    return (op == OP_RD_BYTE) || (op == OP_RD_BIT);
  endfunction

endpackage

// File: rtl/ram_alu.sv
// Combinational modify stage: produces the byte/bit to write back (or report)
// for each micro-op, and flags op codes that have no meaning.
import ram_ctrl_pkg::*;

module ram_alu (
  input  logic [3:0] op_i,
  input  logic [7:0] old_byte_i,
  input  logic       old_bit_i,
  input  logic [7:0] operand_i,
  output logic [7:0] res_byte_o,
  output logic       res_bit_o,
  output logic       illegal_o
);

  always_comb begin
    res_byte_o = 8'h00;
    res_bit_o  = 1'b0;
    illegal_o  = 1'b0;
    case (op_i)
      OP_RD_BYTE: res_byte_o = old_byte_i;
      OP_WR_BYTE: res_byte_o = operand_i;
      OP_INC:     res_byte_o = old_byte_i + 8'd1;
      OP_DEC:     res_byte_o = old_byte_i - 8'd1;
      OP_ANL:     res_byte_o = old_byte_i & operand_i;
      OP_ORL:     res_byte_o = old_byte_i | operand_i;
      OP_XRL:     res_byte_o = old_byte_i ^ operand_i;
      OP_RD_BIT:  res_bit_o  = old_bit_i;
      OP_SETB:    res_bit_o  = 1'b1;
      OP_CLR:     res_bit_o  = 1'b0;
      OP_CPL:     res_bit_o  = ~old_bit_i;
      OP_MOV_BIT: res_bit_o  = operand_i[0];
      default:    illegal_o  = 1'b1;
    endcase
    // Bit ops report their result zero-extended into the byte lane.
    if (op_i[3]) begin
      res_byte_o = {7'b0, res_bit_o};
    end
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Sequences one decoder micro-op at a time onto the internal-RAM port
// (read, modify, write) and returns a single response per command.
import ram_ctrl_pkg::*;

module ram_access_ctrl #(
  parameter logic [7:0] SFR_BASE = SFR_BASE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       ram_rd,
  output logic       ram_wr,
  output logic       ram_is_bit,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_wdata,
  output logic       ram_wbit,
  input  logic [7:0] ram_rdata,
  input  logic       ram_rbit
);

  state_e     state_q;
  logic [3:0] op_q;
  logic [7:0] data_q;
  logic [7:0] result_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_data_q;
  logic       rsp_err_q;
  logic       ram_rd_q;
  logic       ram_wr_q;
  logic       ram_is_bit_q;
  logic [7:0] ram_addr_q;
  logic [7:0] ram_wdata_q;
  logic       ram_wbit_q;

  logic       idle;
  logic [3:0] alu_op;
  logic [7:0] alu_operand;
  logic [7:0] alu_byte;
  logic       alu_bit;
  logic       alu_illegal;
  logic       cmd_reject;

  assign idle      = (state_q == ST_IDLE);
  assign cmd_ready = idle;

  // One ALU serves both paths: in IDLE it evaluates the incoming command so
  // write-only ops have their data ready for the WRITE cycle; in MODIFY it
  // works on the latched command and the freshly read RAM value.
  assign alu_op      = idle ? cmd_op   : op_q;
  assign alu_operand = idle ? cmd_data : data_q;

  ram_alu u_alu (
    .op_i       (alu_op),
    .old_byte_i (ram_rdata),
    .old_bit_i  (ram_rbit),
    .operand_i  (alu_operand),
    .res_byte_o (alu_byte),
    .res_bit_o  (alu_bit),
    .illegal_o  (alu_illegal)
  );

  assign cmd_reject = alu_illegal || (cmd_addr >= SFR_BASE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= 4'h0;
      data_q       <= 8'h00;
      result_q     <= 8'h00;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 8'h00;
      rsp_err_q    <= 1'b0;
      ram_rd_q     <= 1'b1;
      ram_wr_q     <= 1'b0;
      ram_is_bit_q <= 1'b0;
      ram_addr_q   <= 8'h00;
      ram_wdata_q  <= 8'h00;
      ram_wbit_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
            if (cmd_reject) begin
              state_q     <= ST_DONE;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= 8'h00;
              rsp_err_q   <= 1'b1;
            end else begin
              ram_addr_q   <= cmd_addr;
              ram_is_bit_q <= is_bit_op(cmd_op);
              if (is_write_only(cmd_op)) begin
                state_q     <= ST_WRITE;
                ram_rd_q    <= 1'b0;
                ram_wr_q    <= 1'b1;
                ram_wdata_q <= alu_byte;
                ram_wbit_q  <= alu_bit;
                result_q    <= alu_byte;
              end else begin
                state_q <= ST_READ;
              end
            end
          end
        end
        ST_READ: begin
          state_q <= ST_MODIFY;
        end
        ST_MODIFY: begin
          result_q <= alu_byte;
          if (is_read_only(op_q)) begin
            state_q      <= ST_DONE;
            ram_is_bit_q <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_data_q   <= alu_byte;
            rsp_err_q    <= 1'b0;
          end else begin
            state_q     <= ST_WRITE;
            ram_rd_q    <= 1'b0;
            ram_wr_q    <= 1'b1;
            ram_wdata_q <= alu_byte;
            ram_wbit_q  <= alu_bit;
          end
        end
        ST_WRITE: begin
          state_q      <= ST_DONE;
          ram_rd_q     <= 1'b1;
          ram_wr_q     <= 1'b0;
          ram_is_bit_q <= 1'b0;
          rsp_valid_q  <= 1'b1;
          rsp_data_q   <= result_q;
          rsp_err_q    <= 1'b0;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign ram_rd     = ram_rd_q;
  assign ram_wr     = ram_wr_q;
  assign ram_is_bit = ram_is_bit_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign ram_wbit   = ram_wbit_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard bench for ram_access_ctrl: a behavioural 128-byte RAM with
// bit addressing, directed commands with hand-computed responses and latencies.
import ram_ctrl_pkg::*;

module tb_ram_access_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       ram_rd;
  logic       ram_wr;
  logic       ram_is_bit;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_wbit;
  logic [7:0] ram_rdata;
  logic       ram_rbit;

  always #5 clk = ~clk;

  ram_access_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .ram_rd     (ram_rd),
    .ram_wr     (ram_wr),
    .ram_is_bit (ram_is_bit),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_wbit   (ram_wbit),
    .ram_rdata  (ram_rdata),
    .ram_rbit   (ram_rbit)
  );

  // Behavioural RAM: bit address b maps to byte 0x20 + b[6:3], bit b[2:0].
  logic [7:0] mem [0:127];
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    ram_rdata = 8'h00;
    ram_rbit  = 1'b0;
  end

  always @(posedge clk) begin
    if (ram_wr) begin
      if (ram_is_bit) mem[{3'b010, ram_addr[6:3]}][ram_addr[2:0]] <= ram_wbit;
      else            mem[ram_addr[6:0]] <= ram_wdata;
    end
    if (ram_rd) begin
      ram_rdata <= mem[ram_addr[6:0]];
      ram_rbit  <= mem[{3'b010, ram_addr[6:3]}][ram_addr[2:0]];
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         lat;
    int         acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accepts = 0;
  int responses = 0;
  int writes = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && cmd_valid && cmd_ready) accepts++;
    if (ram_wr) writes++;
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h, required 0x%02h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per response pulse.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      responses++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got data 0x%02h err %0b, required no response", rsp_data, rsp_err);
      end else begin
        mon_e = exp_q.pop_front();
        $display("rsp: data 0x%02h err %0b latency %0d (expected 0x%02h err %0b latency %0d)",
                 rsp_data, rsp_err, cyc - mon_e.acc_cyc + 1, mon_e.data, mon_e.err, mon_e.lat);
        check8("rsp_data", rsp_data, mon_e.data);
        check8("rsp_err", {7'b0, rsp_err}, {7'b0, mon_e.err});
        check_int("rsp_latency", cyc - mon_e.acc_cyc + 1, mon_e.lat);
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [7:0] addr, input logic [7:0] data,
                       input logic [7:0] exp_d, input logic exp_err, input int lat,
                       input bit hold);
    exp_t e;
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: cmd_ready %0b, required 1 within 20 cycles", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    e.data    = exp_d;
    e.err     = exp_err;
    e.lat     = lat;
    e.acc_cyc = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cmd_ready !== 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  int acc0, rsp0, wr0;

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 4'h0;
    cmd_addr  = 8'h00;
    cmd_data  = 8'h00;
    #2;
    check8("reset_cmd_ready", {7'b0, cmd_ready}, 8'h01);
    check8("reset_rsp_valid", {7'b0, rsp_valid}, 8'h00);
    check8("reset_rsp_data", rsp_data, 8'h00);
    check8("reset_rsp_err", {7'b0, rsp_err}, 8'h00);
    check8("reset_ram_rd", {7'b0, ram_rd}, 8'h01);
    check8("reset_ram_wr", {7'b0, ram_wr}, 8'h00);
    check8("reset_ram_is_bit", {7'b0, ram_is_bit}, 8'h00);
    check8("reset_ram_addr", ram_addr, 8'h00);
    check8("reset_ram_wdata", ram_wdata, 8'h00);
    check8("reset_ram_wbit", {7'b0, ram_wbit}, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Byte write / read round trip.
    issue(OP_WR_BYTE, 8'h30, 8'h5A, 8'h5A, 1'b0, 2, 1'b0);
    issue(OP_RD_BYTE, 8'h30, 8'h00, 8'h5A, 1'b0, 3, 1'b0);

    // INC wrap, DEC wrap.
    issue(OP_WR_BYTE, 8'h40, 8'hFF, 8'hFF, 1'b0, 2, 1'b0);
    issue(OP_INC,     8'h40, 8'h00, 8'h00, 1'b0, 4, 1'b0);
    issue(OP_RD_BYTE, 8'h40, 8'h00, 8'h00, 1'b0, 3, 1'b0);
    issue(OP_DEC,     8'h40, 8'h00, 8'hFF, 1'b0, 4, 1'b0);

    // Logic RMW ops on 0xF0.
    issue(OP_WR_BYTE, 8'h50, 8'hF0, 8'hF0, 1'b0, 2, 1'b0);
    issue(OP_ANL,     8'h50, 8'h3C, 8'h30, 1'b0, 4, 1'b0);
    issue(OP_ORL,     8'h50, 8'h0F, 8'h3F, 1'b0, 4, 1'b0);
    issue(OP_XRL,     8'h50, 8'hFF, 8'hC0, 1'b0, 4, 1'b0);

    // Bit ops on byte 0x21 (bit address 0x0B is 0x21.3).
    issue(OP_WR_BYTE, 8'h21, 8'h00, 8'h00, 1'b0, 2, 1'b0);
    issue(OP_SETB,    8'h0B, 8'h00, 8'h01, 1'b0, 2, 1'b0);
    issue(OP_RD_BYTE, 8'h21, 8'h00, 8'h08, 1'b0, 3, 1'b0);
    issue(OP_CPL,     8'h0B, 8'h00, 8'h00, 1'b0, 4, 1'b0);
    issue(OP_RD_BIT,  8'h0B, 8'h00, 8'h00, 1'b0, 3, 1'b0);
    issue(OP_MOV_BIT, 8'h0B, 8'h01, 8'h01, 1'b0, 2, 1'b0);
    issue(OP_RD_BYTE, 8'h21, 8'h00, 8'h08, 1'b0, 3, 1'b0);
    issue(OP_CLR,     8'h0B, 8'h00, 8'h00, 1'b0, 2, 1'b0);
    issue(OP_RD_BYTE, 8'h21, 8'h00, 8'h00, 1'b0, 3, 1'b0);
    issue(OP_WR_BYTE, 8'h7F, 8'hA5, 8'hA5, 1'b0, 2, 1'b0);
    drain();

    // Rejected commands: no RAM write may occur.
    wr0 = writes;
    issue(OP_RD_BYTE, 8'h90, 8'h00, 8'h00, 1'b1, 1, 1'b0);
    issue(4'h7,       8'h10, 8'h00, 8'h00, 1'b1, 1, 1'b0);
    issue(OP_WR_BYTE, 8'h80, 8'h11, 8'h00, 1'b1, 1, 1'b0);
    issue(OP_SETB,    8'h80, 8'h00, 8'h00, 1'b1, 1, 1'b0);
    issue(4'hF,       8'h00, 8'h00, 8'h00, 1'b1, 1, 1'b0);
    drain();
    check_int("error_ram_writes", writes - wr0, 0);

    // Reset during WRITE of ANL 0x30 (old 0xF0, data 0x3C).
    issue(OP_WR_BYTE, 8'h30, 8'hF0, 8'hF0, 1'b0, 2, 1'b0);
    drain();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_ANL;
    cmd_addr  = 8'h30;
    cmd_data  = 8'h3C;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check8("anl_in_write_ram_wr", {7'b0, ram_wr}, 8'h01);
    rst = 1'b1;
    #1;
    check8("abort_ram_wr", {7'b0, ram_wr}, 8'h00);
    check8("abort_ram_rd", {7'b0, ram_rd}, 8'h01);
    check8("abort_rsp_valid", {7'b0, rsp_valid}, 8'h00);
    check8("abort_ram_addr", ram_addr, 8'h00);
    check8("abort_ram_is_bit", {7'b0, ram_is_bit}, 8'h00);
    check8("abort_ram_wdata", ram_wdata, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check8("abort_cmd_ready", {7'b0, cmd_ready}, 8'h01);
    repeat (4) @(negedge clk);
    issue(OP_RD_BYTE, 8'h30, 8'h00, 8'hF0, 1'b0, 3, 1'b0);
    drain();

    // Three back-to-back ORL with cmd_valid held high.
    issue(OP_WR_BYTE, 8'h60, 8'h00, 8'h00, 1'b0, 2, 1'b0);
    drain();
    acc0 = accepts;
    rsp0 = responses;
    issue(OP_ORL, 8'h60, 8'h01, 8'h01, 1'b0, 4, 1'b1);
    issue(OP_ORL, 8'h60, 8'h02, 8'h03, 1'b0, 4, 1'b1);
    issue(OP_ORL, 8'h60, 8'h04, 8'h07, 1'b0, 4, 1'b0);
    drain();
    repeat (6) @(negedge clk);
    check_int("b2b_accepts", accepts - acc0, 3);
    check_int("b2b_responses", responses - rsp0, 3);
    check_int("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Initiator-side sequencer for the 8051 internal data RAM. Accepts one memory micro-op at a time from the instruction decoder (byte read/write, byte read-modify-write, bit read/write/complement) and drives the RAM's rd/wr/is_bit_addr/addr/data port. It performs the read → modify → write sequencing that direct-address instructions need (INC/DEC/ANL/ORL/XRL direct, SETB/CLR/CPL bit), then returns one response per command.

## Interface
- SFR_BASE, 8'h80, first address of the SFR region; byte and bit addresses ≥ SFR_BASE are rejected.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE; a command is accepted on an edge where cmd_valid && cmd_ready.
- cmd_op  in  4  micro-op: 0 RD_BYTE, 1 WR_BYTE, 2 INC, 3 DEC, 4 ANL, 5 ORL, 6 XRL, 8 RD_BIT, 9 SETB, A CLR, B CPL, C MOV_BIT; others illegal.
- cmd_addr  in  8  byte address, or bit address for ops 8–C.
- cmd_data  in  8  operand for WR_BYTE/ANL/ORL/XRL; bit 0 is the operand for MOV_BIT.
- rsp_valid  out  1  one-cycle pulse; response fields are valid in that cycle.
- rsp_data  out  8  byte result; for bit ops, {7'b0, bit}.
- rsp_err  out  1  illegal op or SFR-range address.
- ram_rd, ram_wr, ram_is_bit  out  1 each  RAM control.
- ram_addr  out  8; ram_wdata  out  8; ram_wbit  out  1.
- ram_rdata  in  8; ram_rbit  in  1  RAM read results, registered inside the RAM one edge after a read.

## Operation
- States: IDLE, READ, MODIFY, WRITE, DONE.
- Command latching: on accept, latch op, addr and data into registers. cmd_* is ignored outside IDLE.
- Transitions from IDLE:
  - Illegal op or addr ≥ SFR_BASE → DONE with rsp_err=1 and rsp_data=0. No RAM write occurs.
  - Write-only ops (WR_BYTE, SETB, CLR, MOV_BIT) → WRITE.
  - All other ops → READ.
- READ → MODIFY, always.
- MODIFY:
  - Compute the result from ram_rdata/ram_rbit and register it.
  - Read-only ops (RD_BYTE, RD_BIT) → DONE; everything else → WRITE.
- WRITE → DONE. DONE → IDLE.
- Modify rules (8-bit, modulo 256):
  - INC: old+1; 0xFF wraps to 0x00.
  - DEC: old−1; 0x00 wraps to 0xFF.
  - ANL: old&data. ORL: old|data. XRL: old^data.
  - CPL: ~bit.
  - SETB writes 1; CLR writes 0; MOV_BIT writes data[0].
- Response content:
  - RMW ops return the new value.
  - Read ops return the value read.
  - Write-only ops return the written value.
- RAM port rules:
  - ram_rd = 1 in every state except WRITE. The RAM treats rd=0 in byte mode as a write, so an idle controller parks on a harmless read.
  - ram_wr = 1 only in WRITE.
  - ram_is_bit = 1 for ops 8–C from READ through WRITE.
  - ram_addr holds the latched addr from READ through WRITE.
- No flags or PSW updates: INC/DEC carry and parity are out of scope.

## Timing
- All outputs are registered, except cmd_ready, which equals (state==IDLE).
- Accept edge is cycle 0. rsp_valid rises in:
  - cycle 2 for write-only ops;
  - cycle 3 for reads;
  - cycle 4 for RMW ops;
  - cycle 1 for errors.
- Throughput: the next command can be accepted in the cycle after DONE.
- ram_rdata/ram_rbit are sampled only in MODIFY, one edge after READ drove ram_rd=1 with the correct address and ram_is_bit.
- Reset values:
  - state IDLE, cmd_ready 1, rsp_valid 0, rsp_data 0, rsp_err 0;
  - ram_rd 1, ram_wr 0, ram_is_bit 0, ram_addr 0, ram_wdata 0, ram_wbit 0.
- Reset mid-operation aborts the command immediately. No response is issued and no further write is issued.
- cmd_valid held high across DONE is not accepted until IDLE. One command is accepted per IDLE cycle.

## Structure
- Package ram_ctrl_pkg: op encodings, state enum, SFR_BASE default.
- Sub-module ram_alu: combinational; inputs are op, old byte, old bit and operand; outputs are the result byte/bit and an illegal flag.
- The FSM and port registers live in ram_access_ctrl.

## Test plan
- WR_BYTE addr 0x30 data 0x5A, then RD_BYTE 0x30 → RD_BYTE response rsp_data=0x5A, rsp_err=0. Write rsp_valid at cycle 2, read rsp_valid at cycle 3 after their own accepts.
- WR_BYTE 0x40=0xFF, then INC 0x40 → rsp_data=0x00 at cycle 4 after accept. RD_BYTE 0x40 then returns 0x00. DEC of 0x00 gives 0xFF.
- Bit operations, starting with byte 0x21=0x00:
  - SETB bit 0x0B → byte 0x21 reads 0x08.
  - CPL 0x0B → rsp_data=0x00.
  - RD_BIT 0x0B → rsp_data=0x00.
- Errors: RD_BYTE 0x90, and op 0x7 at 0x10 → rsp_err=1 at cycle 1. ram_wr stays 0 throughout.
- Assert rst during the WRITE cycle of ANL 0x30 (old 0xF0, data 0x3C) → no rsp_valid is issued. Outputs take reset values asynchronously and cmd_ready=1 after release.
- Hold cmd_valid high for 3 back-to-back ORL commands → exactly 3 accepts and 3 responses, with in-order results.
